// File: rtl/adc_stream_packer.sv
// Drains 32-bit ADC samples from the output FIFO and serialises them as numbered byte frames:
// sync, seq, count, big-endian samples, then an additive checksum, over a valid/ready stream.
module adc_stream_packer #(
  parameter int         FRAME_LEN = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_rd_data,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int         IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [7:0] FL = 8'(FRAME_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SYNC, S_SEQ, S_LEN, S_DATA, S_CSUM
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n, cnt_cap;
  logic        pend, pend_n;
  logic        flush_pend, flush_pend_n;
  logic [7:0]  seq, seq_n;
  logic [7:0]  csum, csum_n;
  logic [9:0]  byte_idx, byte_idx_n, nidx;
  logic [7:0]  m_data_n;
  logic        m_valid_n, m_last_n;
  logic [15:0] frame_cnt_n;
  logic [31:0] sample_buf [FRAME_LEN];
  logic [31:0] word;
  logic [7:0]  next_byte;
  logic        hs, leave_fill;

  assign busy = (state != S_IDLE);
  assign hs   = m_valid & m_ready;

  always_comb begin
    nidx = (state == S_LEN) ? 10'd0 : byte_idx + 10'd1;
    word = sample_buf[nidx[IW+1:2]];
    case (nidx[1:0])
      2'd0:    next_byte = word[31:24];
      2'd1:    next_byte = word[23:16];
      2'd2:    next_byte = word[15:8];
      default: next_byte = word[7:0];
    endcase
  end

  // Exit decisions use the count including this cycle's capture, so the last sample and SYNC
  // are only one cycle apart; no new read is issued in the exit cycle.
  assign cnt_cap    = cnt + {7'd0, pend};
  assign leave_fill = (cnt_cap == FL) || ((flush_pend || !enable) && (cnt_cap != 8'd0));

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    pend_n       = pend;
    flush_pend_n = flush_pend | flush;
    seq_n        = seq;
    csum_n       = csum;
    byte_idx_n   = byte_idx;
    m_data_n     = m_data;
    m_valid_n    = m_valid;
    m_last_n     = m_last;
    frame_cnt_n  = frame_cnt;
    fifo_rd_en   = 1'b0;
    case (state)
      S_IDLE: if (enable) state_n = S_FILL;
      S_FILL: begin
        cnt_n = cnt_cap;
        if (leave_fill) begin
          state_n   = S_SYNC;
          m_valid_n = 1'b1;
          m_data_n  = SYNC_BYTE;
          m_last_n  = 1'b0;
          csum_n    = 8'd0;
        end else if (!enable) begin
          state_n = S_IDLE;
        end else begin
          if (flush_pend) flush_pend_n = flush;
          fifo_rd_en = !fifo_empty;
        end
        pend_n = fifo_rd_en;
      end
      S_SYNC: if (hs) begin
        state_n  = S_SEQ;
        m_data_n = seq;
      end
      S_SEQ: if (hs) begin
        state_n  = S_LEN;
        m_data_n = cnt;
        csum_n   = csum + m_data;
      end
      S_LEN: if (hs) begin
        state_n    = S_DATA;
        byte_idx_n = 10'd0;
        m_data_n   = next_byte;
        csum_n     = csum + m_data;
      end
      S_DATA: if (hs) begin
        csum_n = csum + m_data;
        if (byte_idx == ({2'b00, cnt, 2'b00} - 10'd1)) begin
          state_n  = S_CSUM;
          m_data_n = csum + m_data;
          m_last_n = 1'b1;
        end else begin
          byte_idx_n = byte_idx + 10'd1;
          m_data_n   = next_byte;
        end
      end
      S_CSUM: if (hs) begin
        m_valid_n    = 1'b0;
        m_last_n     = 1'b0;
        m_data_n     = 8'd0;
        cnt_n        = 8'd0;
        flush_pend_n = flush;
        seq_n        = seq + 8'd1;
        frame_cnt_n  = frame_cnt + 16'd1;
        state_n      = enable ? S_FILL : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      pend       <= 1'b0;
      flush_pend <= 1'b0;
      seq        <= 8'd0;
      csum       <= 8'd0;
      byte_idx   <= 10'd0;
      m_data     <= 8'd0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      flush_pend <= flush_pend_n;
      seq        <= seq_n;
      csum       <= csum_n;
      byte_idx   <= byte_idx_n;
      m_data     <= m_data_n;
      m_valid    <= m_valid_n;
      m_last     <= m_last_n;
      frame_cnt  <= frame_cnt_n;
    end
  end

  // Sample storage needs no reset: cnt decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (state == S_FILL && pend) sample_buf[cnt[IW-1:0]] <= fifo_rd_data;
  end

endmodule

// File: doc/adc_stream_packer.md
# adc_stream_packer

Downstream consumer of the WETOP ADC output FIFO. It drains 32-bit ADC samples from that FIFO and groups them into numbered frames. Each frame is serialised as a byte stream with a valid/ready handshake, ready for the host link (UART/BLE bridge). Each frame carries a sync byte, a sequence number, a sample count, big-endian samples and an additive checksum.

## Interface
Parameters:
- FRAME_LEN, 16: samples per full frame, range 1..255.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk, in, 1: system clock (512 kHz).
- rst, in, 1: synchronous reset, active-low (0 = reset), sampled on rising clk.
- enable, in, 1: 1 = collect and emit frames. 0 = finish the current frame, then idle.
- flush, in, 1: one-cycle pulse. Emits a partial frame from the samples buffered so far.
- fifo_empty, in, 1: ADC output FIFO empty flag.
- fifo_rd_en, out, 1: ADC output FIFO read enable (drives adc_out_rd).
- fifo_rd_data, in, 32: ADC output FIFO data (data_out_adc). Valid the cycle after fifo_rd_en.
- m_data, out, 8: stream byte.
- m_valid, out, 1: m_data valid.
- m_ready, in, 1: sink accepts the byte when m_valid & m_ready.
- m_last, out, 1: high with the checksum byte.
- busy, out, 1: high in any state other than IDLE.
- frame_cnt, out, 16: frames fully emitted since reset. Wraps at 65535.

## Operation
- Frame bytes, in order:
  - SYNC_BYTE
  - seq[7:0]
  - N, where 1 ≤ N ≤ FRAME_LEN
  - N samples, 4 bytes each, MSB first
  - csum
- Frame length = 4N+4 bytes.
- csum = (seq + N + all sample bytes) mod 256. SYNC_BYTE is excluded from the sum.
- seq starts at 0 and increments by 1 mod 256 after each checksum byte is accepted.
- Internal buffer: FRAME_LEN x 32 registers, plus count cnt and pending-read flag pend.
- State machine:
  - IDLE: enable=1 -> FILL.
  - FILL:
    - Assert fifo_rd_en when !fifo_empty and cnt+pend < FRAME_LEN.
    - Capture fifo_rd_data into buf[cnt] the cycle after each read, then cnt++.
    - Go to SYNC when (cnt==FRAME_LEN) or (flush_pend and cnt≥1 and !pend).
    - flush_pend with cnt==0 and !pend: clear flush_pend, stay in FILL.
    - enable=0 with cnt==0 and !pend -> IDLE.
  - SYNC -> SEQ -> LEN -> DATA -> CSUM: each state advances on the m_valid & m_ready handshake.
    - DATA iterates byte index 0..4N-1.
    - CSUM on handshake: cnt=0, flush_pend=0, seq++, frame_cnt++. Then go to FILL if enable, else IDLE.
- flush is latched into flush_pend. A flush arriving outside FILL is held until the next FILL.
- fifo_rd_en is never asserted outside FILL.
- The FIFO guarantees fifo_empty reflects every prior rd_en, so back-to-back reads are legal.
- enable falling during FILL with cnt≥1: the buffered samples are emitted as a partial frame, the same as a flush.

## Timing
- Reset values: m_valid=0, m_data=0, m_last=0, fifo_rd_en=0, busy=0, frame_cnt=0. Internally seq=0, cnt=0, pend=0, flush_pend=0, state IDLE.
- Reset mid-frame: the next cycle after rst=0 matches the reset values. The partial frame and buffered samples are discarded and no checksum byte is sent.
- Read latency: fifo_rd_en in cycle t -> data captured at the end of cycle t+1.
- Full-rate fill takes FRAME_LEN+1 cycles from the first read to SYNC.
- The SYNC byte appears on m_valid in the cycle after the FILL exit condition is met.
- With m_ready held at 1: one byte per cycle, no gaps inside a frame.
- m_data, m_valid and m_last are registered. While m_valid & !m_ready they hold stable.
- m_valid is never deasserted without a handshake.
- A simultaneous flush and final-sample capture (cnt reaches FRAME_LEN) produces a full frame. flush_pend is cleared at CSUM, so no extra empty frame follows.

## Test plan
- FRAME_LEN=4, samples 1,2,3,4, m_ready=1 -> 20 bytes:
  - A5 00 04, then 00 00 00 01 / 00 00 00 02 / 00 00 00 03 / 00 00 00 04, then 0E.
  - m_last only on 0E. frame_cnt=1.
- Same stimulus with m_ready toggling 1,0 every cycle -> identical byte sequence. m_data stable during every stall.
- One sample 0xDEADBEEF, then a flush pulse -> A5 00 01 DE AD BE EF 39, frame_cnt=1.
- Flush with an empty buffer -> no m_valid for 50 cycles, flush_pend cleared. A subsequent full frame has seq=00.
- 257 consecutive full frames -> the seq byte of frame 257 is 00 and frame_cnt=257.
- rst=0 asserted during DATA byte 2 -> the following cycle m_valid=0, busy=0, frame_cnt=0. After release, the first frame starts with A5 00.
